// File: rtl/dmem_req_bridge_pkg.sv
// Shared types and helpers for the data-memory request bridge: FSM states,
// access-size codes, the queued request entry and size-dependent data shaping.
package dmem_req_bridge_pkg;

   localparam int QUEUE_DEPTH_DEFAULT = 4;

   localparam logic [1:0] SIZE_BYTE   = 2'd0;
   localparam logic [1:0] SIZE_HALF   = 2'd1;
   localparam logic [1:0] SIZE_WORD   = 2'd2;
   localparam logic [1:0] SIZE_DOUBLE = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      LD_ISSUE,
      LD_WAIT,
      ST_ISSUE,
      RESP
   } state_e;

   typedef struct packed {
      logic        is_store;
      logic [63:0] address;
      logic [1:0]  size;
      logic        signed_ld;
      logic [63:0] data;
      logic [3:0]  tag;
   } req_entry_t;

   function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
      logic r;
      case (size)
         SIZE_HALF:   r = addr_lo[0];
         SIZE_WORD:   r = |addr_lo[1:0];
         SIZE_DOUBLE: r = |addr_lo[2:0];
         default:     r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [63:0] extend_load(input logic [63:0] d, input logic [1:0] size,
                                               input logic sgn);
      logic [63:0] r;
      case (size)
         SIZE_BYTE: r = {{56{sgn & d[7]}}, d[7:0]};
         SIZE_HALF: r = {{48{sgn & d[15]}}, d[15:0]};
         SIZE_WORD: r = {{32{sgn & d[31]}}, d[31:0]};
         default:   r = d;
      endcase
      return r;
   endfunction

   function automatic logic [63:0] mask_store(input logic [63:0] d, input logic [1:0] size);
      return extend_load(d, size, 1'b0);
   endfunction

endpackage

// File: rtl/dmem_req_bridge_fifo.sv
// In-order request queue with registered head; full/empty derived from an
// occupancy counter, pointers wrap naturally since DEPTH is a power of two.
module req_fifo
   import dmem_req_bridge_pkg::*;
#(
   parameter int  DEPTH   = QUEUE_DEPTH_DEFAULT,
   parameter type entry_t = req_entry_t
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   push,
   input  entry_t push_data,
   output logic   full,
   input  logic   pop,
   output logic   empty,
   output entry_t head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     count_q, count_d;
   logic               do_push, do_pop;

   always_comb begin
      full     = (count_q == (PTR_W+1)'(DEPTH));
      empty    = (count_q == '0);
      head     = mem_q[rd_ptr_q];
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/dmem_req_bridge.sv
// Bridges a queued core load/store request stream onto split memory read and
// write channels, one memory transaction in flight, responses returned in order.
module dmem_req_bridge
   import dmem_req_bridge_pkg::*;
#(
   parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_bits_isStore,
   input  logic [63:0] req_bits_address,
   input  logic [1:0]  req_bits_size,
   input  logic        req_bits_signed,
   input  logic [63:0] req_bits_data,
   input  logic [3:0]  req_bits_tag,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_bits_data,
   output logic [3:0]  resp_bits_tag,
   output logic        resp_bits_isStore,
   output logic        resp_bits_error,
   output logic        mem_dRead_addressInfo_valid,
   input  logic        mem_dRead_addressInfo_ready,
   output logic [63:0] mem_dRead_addressInfo_bits_address,
   output logic [1:0]  mem_dRead_addressInfo_bits_size,
   input  logic        mem_dRead_data_valid,
   output logic        mem_dRead_data_ready,
   input  logic [63:0] mem_dRead_data_bits,
   output logic        mem_dWrite_storeInfo_valid,
   input  logic        mem_dWrite_storeInfo_ready,
   output logic [63:0] mem_dWrite_storeInfo_bits_addressInfo_address,
   output logic [1:0]  mem_dWrite_storeInfo_bits_addressInfo_size,
   output logic [63:0] mem_dWrite_storeInfo_bits_data
);

   state_e     state_q, state_d;
   req_entry_t cur_q, cur_d;
   logic [63:0] rdata_q, rdata_d;
   req_entry_t push_entry, fifo_head;
   logic       fifo_full, fifo_empty, fifo_push, fifo_pop, cur_err;

   always_comb begin
      push_entry = '{is_store: req_bits_isStore, address: req_bits_address, size: req_bits_size,
                     signed_ld: req_bits_signed, data: req_bits_data, tag: req_bits_tag};
      fifo_push  = req_valid && req_ready;
      fifo_pop   = resp_valid && resp_ready;
   end

   req_fifo #(.DEPTH(QUEUE_DEPTH), .entry_t(req_entry_t)) u_req_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (push_entry),
      .full      (fifo_full),
      .pop       (fifo_pop),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   // The head stays queued until its response fires; cur_q is a working copy.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               cur_d = fifo_head;
               if (is_misaligned(fifo_head.address[2:0], fifo_head.size)) state_d = RESP;
               else if (fifo_head.is_store)                              state_d = ST_ISSUE;
               else                                                      state_d = LD_ISSUE;
            end
         end
         LD_ISSUE: if (mem_dRead_addressInfo_ready) state_d = LD_WAIT;
         LD_WAIT: begin
            if (mem_dRead_data_valid) begin
               rdata_d = extend_load(mem_dRead_data_bits, cur_q.size, cur_q.signed_ld);
               state_d = RESP;
            end
         end
         ST_ISSUE: if (mem_dWrite_storeInfo_ready) state_d = RESP;
         RESP:     if (resp_ready) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      cur_q   <= cur_d;
      rdata_q <= rdata_d;
   end

   // Outputs are forced low during reset, independent of the registered state.
   always_comb begin
      cur_err = is_misaligned(cur_q.address[2:0], cur_q.size);
      req_ready = !reset && !fifo_full;

      mem_dRead_addressInfo_valid        = !reset && (state_q == LD_ISSUE);
      mem_dRead_addressInfo_bits_address = '0;
      mem_dRead_addressInfo_bits_size    = '0;
      if (mem_dRead_addressInfo_valid) begin
         mem_dRead_addressInfo_bits_address = cur_q.address;
         mem_dRead_addressInfo_bits_size    = cur_q.size;
      end
      mem_dRead_data_ready = !reset && (state_q == LD_WAIT);

      mem_dWrite_storeInfo_valid                   = !reset && (state_q == ST_ISSUE);
      mem_dWrite_storeInfo_bits_addressInfo_address = '0;
      mem_dWrite_storeInfo_bits_addressInfo_size    = '0;
      mem_dWrite_storeInfo_bits_data                = '0;
      if (mem_dWrite_storeInfo_valid) begin
         mem_dWrite_storeInfo_bits_addressInfo_address = cur_q.address;
         mem_dWrite_storeInfo_bits_addressInfo_size    = cur_q.size;
         mem_dWrite_storeInfo_bits_data                = mask_store(cur_q.data, cur_q.size);
      end

      resp_valid        = !reset && (state_q == RESP);
      resp_bits_data    = '0;
      resp_bits_tag     = '0;
      resp_bits_isStore = 1'b0;
      resp_bits_error   = 1'b0;
      if (resp_valid) begin
         resp_bits_data    = (cur_q.is_store || cur_err) ? 64'd0 : rdata_q;
         resp_bits_tag     = cur_q.tag;
         resp_bits_isStore = cur_q.is_store;
         resp_bits_error   = cur_err;
      end
   end

endmodule

// File: tb/tb_dmem_req_bridge.sv
// Directed bench for dmem_req_bridge: reset, loads, stores, misalignment,
// FIFO back-pressure, address-channel stall and reset during an outstanding load.
module tb_dmem_req_bridge;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0, req_ready;
   logic        req_bits_isStore = 1'b0;
   logic [63:0] req_bits_address = '0;
   logic [1:0]  req_bits_size = '0;
   logic        req_bits_signed = 1'b0;
   logic [63:0] req_bits_data = '0;
   logic [3:0]  req_bits_tag = '0;
   logic        resp_valid, resp_ready = 1'b0;
   logic [63:0] resp_bits_data;
   logic [3:0]  resp_bits_tag;
   logic        resp_bits_isStore, resp_bits_error;
   logic        ar_valid, ar_ready = 1'b0;
   logic [63:0] ar_addr;
   logic [1:0]  ar_size;
   logic        rd_valid = 1'b0, rd_ready;
   logic [63:0] rd_bits = '0;
   logic        st_valid, st_ready = 1'b0;
   logic [63:0] st_addr, st_data;
   logic [1:0]  st_size;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_req_bridge #(.QUEUE_DEPTH(4)) dut (
      .clk                                          (clk),
      .reset                                        (reset),
      .req_valid                                    (req_valid),
      .req_ready                                    (req_ready),
      .req_bits_isStore                             (req_bits_isStore),
      .req_bits_address                             (req_bits_address),
      .req_bits_size                                (req_bits_size),
      .req_bits_signed                              (req_bits_signed),
      .req_bits_data                                (req_bits_data),
      .req_bits_tag                                 (req_bits_tag),
      .resp_valid                                   (resp_valid),
      .resp_ready                                   (resp_ready),
      .resp_bits_data                               (resp_bits_data),
      .resp_bits_tag                                (resp_bits_tag),
      .resp_bits_isStore                            (resp_bits_isStore),
      .resp_bits_error                              (resp_bits_error),
      .mem_dRead_addressInfo_valid                  (ar_valid),
      .mem_dRead_addressInfo_ready                  (ar_ready),
      .mem_dRead_addressInfo_bits_address           (ar_addr),
      .mem_dRead_addressInfo_bits_size              (ar_size),
      .mem_dRead_data_valid                         (rd_valid),
      .mem_dRead_data_ready                         (rd_ready),
      .mem_dRead_data_bits                          (rd_bits),
      .mem_dWrite_storeInfo_valid                   (st_valid),
      .mem_dWrite_storeInfo_ready                   (st_ready),
      .mem_dWrite_storeInfo_bits_addressInfo_address(st_addr),
      .mem_dWrite_storeInfo_bits_addressInfo_size   (st_size),
      .mem_dWrite_storeInfo_bits_data               (st_data)
   );

   // Offers one request and returns on the negedge after it was accepted.
   task automatic send_req(input logic st, input logic [63:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [63:0] data, input logic [3:0] tag);
      bit ok = 0;
      @(negedge clk);
      req_bits_isStore = st; req_bits_address = addr; req_bits_size = size;
      req_bits_signed = sgn; req_bits_data = data; req_bits_tag = tag; req_valid = 1'b1;
      for (int n = 0; n < 40 && !ok; n++) begin
         #1;
         if (req_ready === 1'b1) ok = 1;
         @(negedge clk);
      end
      req_valid = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL send_req tag %0h: accepted=0 required=1", tag); end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({req_ready, resp_valid, ar_valid, rd_ready, st_valid} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b required 00000", {req_ready, resp_valid, ar_valid, rd_ready, st_valid});
      end
      checks++;
      if ({resp_bits_data, ar_addr, st_addr, st_data} !== '0) begin
         errors++; $display("FAIL reset_bits got nonzero data/address outputs required 0");
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b required 1", req_ready); end
   endtask

   task automatic run_byte_load(input logic sgn, input logic [63:0] exp);
      send_req(1'b0, 64'h1003, 2'd0, sgn, 64'h0, 4'h5);
      @(negedge clk); #1;
      checks++;
      if (ar_valid !== 1'b1 || ar_addr !== 64'h1003 || ar_size !== 2'd0) begin
         errors++; $display("FAIL ld_byte_ar got v=%b a=%h s=%0d required v=1 a=1003 s=0", ar_valid, ar_addr, ar_size);
      end
      ar_ready = 1'b1;
      @(negedge clk); ar_ready = 1'b0; #1;
      checks++;
      if (rd_ready !== 1'b1) begin errors++; $display("FAIL ld_byte_rd_ready got %b required 1", rd_ready); end
      rd_valid = 1'b1; rd_bits = 64'hDEAD_BEEF_CAFE_1280;
      @(negedge clk); rd_valid = 1'b0; #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_bits_data !== exp || resp_bits_tag !== 4'h5 ||
          resp_bits_error !== 1'b0 || resp_bits_isStore !== 1'b0) begin
         errors++;
         $display("FAIL ld_byte_resp sgn=%b got v=%b d=%h t=%h e=%b required v=1 d=%h t=5 e=0",
                  sgn, resp_valid, resp_bits_data, resp_bits_tag, resp_bits_error, exp);
      end
      resp_ready = 1'b1;
      @(negedge clk); resp_ready = 1'b0; #1;
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL ld_byte_resp_drop got %b required 0", resp_valid); end
   endtask

   task automatic test_load_byte();
      run_byte_load(1'b1, 64'hFFFF_FFFF_FFFF_FF80);
      run_byte_load(1'b0, 64'h0000_0000_0000_0080);
   endtask

   task automatic test_store_half();
      send_req(1'b1, 64'h2002, 2'd1, 1'b0, 64'h1234_5678, 4'h3);
      @(negedge clk); #1;
      checks++;
      if (st_valid !== 1'b1 || st_addr !== 64'h2002 || st_size !== 2'd1 || st_data !== 64'h5678 || ar_valid !== 1'b0) begin
         errors++;
         $display("FAIL st_half_req got v=%b a=%h s=%0d d=%h ar=%b required v=1 a=2002 s=1 d=5678 ar=0",
                  st_valid, st_addr, st_size, st_data, ar_valid);
      end
      st_ready = 1'b1;
      @(negedge clk); st_ready = 1'b0; #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_bits_isStore !== 1'b1 || resp_bits_data !== 64'd0 ||
          resp_bits_tag !== 4'h3 || st_valid !== 1'b0) begin
         errors++;
         $display("FAIL st_half_resp got v=%b st=%b d=%h t=%h wv=%b required v=1 st=1 d=0 t=3 wv=0",
                  resp_valid, resp_bits_isStore, resp_bits_data, resp_bits_tag, st_valid);
      end
      resp_ready = 1'b1;
      @(negedge clk); resp_ready = 1'b0;
   endtask

   task automatic test_misaligned();
      send_req(1'b0, 64'h1001, 2'd2, 1'b0, 64'h0, 4'h7);
      #1;
      checks++;
      if (ar_valid !== 1'b0) begin errors++; $display("FAIL mis_ar_idle got %b required 0", ar_valid); end
      @(negedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_bits_error !== 1'b1 || resp_bits_data !== 64'd0 ||
          resp_bits_tag !== 4'h7 || ar_valid !== 1'b0) begin
         errors++;
         $display("FAIL mis_resp got v=%b e=%b d=%h t=%h ar=%b required v=1 e=1 d=0 t=7 ar=0",
                  resp_valid, resp_bits_error, resp_bits_data, resp_bits_tag, ar_valid);
      end
      resp_ready = 1'b1;
      @(negedge clk); resp_ready = 1'b0;
   endtask

   task automatic test_ar_stall();
      send_req(1'b0, 64'h3008, 2'd3, 1'b1, 64'h0, 4'h9);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         checks++;
         if (ar_valid !== 1'b1 || ar_addr !== 64'h3008 || ar_size !== 2'd3) begin
            errors++;
            $display("FAIL stall_ar cycle %0d got v=%b a=%h s=%0d required v=1 a=3008 s=3", i, ar_valid, ar_addr, ar_size);
         end
      end
      ar_ready = 1'b1;
      @(negedge clk); ar_ready = 1'b0;
      rd_valid = 1'b1; rd_bits = 64'h8123_4567_89AB_CDEF;
      @(negedge clk); rd_valid = 1'b0; #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_bits_data !== 64'h8123_4567_89AB_CDEF || resp_bits_tag !== 4'h9) begin
         errors++;
         $display("FAIL stall_resp got v=%b d=%h t=%h required v=1 d=8123456789abcdef t=9", resp_valid, resp_bits_data, resp_bits_tag);
      end
      resp_ready = 1'b1;
      @(negedge clk); resp_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      st_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         req_valid = 1'b1; req_bits_isStore = 1'b1; req_bits_address = 64'h5000 + 64'(i);
         req_bits_size = 2'd0; req_bits_data = 64'(i); req_bits_tag = 4'(i);
         #1;
         checks++;
         if (req_ready !== (i < 4)) begin
            errors++; $display("FAIL b2b_ready req %0d got %b required %b", i, req_ready, (i < 4));
         end
      end
      repeat (2) begin
         @(negedge clk); #1;
         checks++;
         if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_hold got %b required 0", req_ready); end
      end
      @(negedge clk); resp_ready = 1'b1; #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_bits_tag !== 4'h0 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_pop_cycle got v=%b t=%h rdy=%b required v=1 t=0 rdy=0", resp_valid, resp_bits_tag, req_ready);
      end
      @(negedge clk); resp_ready = 1'b0; #1;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_after_pop got %b required 1", req_ready); end
      @(negedge clk); req_valid = 1'b0;
      for (int k = 1; k < 5; k++) begin
         int n;
         n = 0;
         @(negedge clk); #1;
         while (resp_valid !== 1'b1 && n < 12) begin @(negedge clk); #1; n++; end
         checks++;
         if (resp_valid !== 1'b1 || resp_bits_tag !== 4'(k)) begin
            errors++; $display("FAIL b2b_drain got v=%b t=%h required v=1 t=%0h", resp_valid, resp_bits_tag, k);
         end
         resp_ready = 1'b1;
         @(negedge clk); resp_ready = 1'b0;
      end
      st_ready = 1'b0;
   endtask

   task automatic test_reset_in_flight();
      send_req(1'b0, 64'h4000, 2'd3, 1'b0, 64'h0, 4'hA);
      @(negedge clk); ar_ready = 1'b1;
      @(negedge clk); ar_ready = 1'b0; #1;
      checks++;
      if (rd_ready !== 1'b1) begin errors++; $display("FAIL rst_fl_wait got %b required 1", rd_ready); end
      reset = 1'b1; #1;
      checks++;
      if ({rd_ready, resp_valid, req_ready} !== 3'b0) begin
         errors++; $display("FAIL rst_fl_outputs got %b required 000", {rd_ready, resp_valid, req_ready});
      end
      @(negedge clk); reset = 1'b0;
      rd_valid = 1'b1; rd_bits = 64'h1111_2222_3333_4444;
      @(negedge clk); rd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (resp_valid !== 1'b0 || ar_valid !== 1'b0) begin
            errors++; $display("FAIL rst_fl_stale cycle %0d got rv=%b av=%b required 0 0", i, resp_valid, ar_valid);
         end
         @(negedge clk);
      end
      send_req(1'b0, 64'h4008, 2'd2, 1'b0, 64'h0, 4'hB);
      @(negedge clk); #1;
      checks++;
      if (ar_valid !== 1'b1 || ar_addr !== 64'h4008 || ar_size !== 2'd2) begin
         errors++; $display("FAIL rst_fl_next_ar got v=%b a=%h s=%0d required v=1 a=4008 s=2", ar_valid, ar_addr, ar_size);
      end
      ar_ready = 1'b1;
      @(negedge clk); ar_ready = 1'b0;
      rd_valid = 1'b1; rd_bits = 64'hFFFF_FFFF_8000_0001;
      @(negedge clk); rd_valid = 1'b0; #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_bits_data !== 64'h0000_0000_8000_0001 || resp_bits_tag !== 4'hB) begin
         errors++;
         $display("FAIL rst_fl_next_resp got v=%b d=%h t=%h required v=1 d=80000001 t=b", resp_valid, resp_bits_data, resp_bits_tag);
      end
      resp_ready = 1'b1;
      @(negedge clk); resp_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_byte();
      test_store_half();
      test_misaligned();
      test_ar_stall();
      test_back_to_back();
      test_reset_in_flight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/dmem_req_bridge.md
DMEM_REQ_BRIDGE -- requirements
Module: dmem_req_bridge

Interface
REQ-001 Parameter QUEUE_DEPTH, default 4, request FIFO entries (power of two, >=2).
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 req_valid / req_ready  in / out  1 / 1  core request handshake; fires when both are high.
REQ-005 req_bits_isStore  in  1  1 = store, 0 = load.
REQ-006 req_bits_address  in  64  byte address.
REQ-007 req_bits_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
REQ-008 req_bits_signed  in  1  load sign-extends when 1, zero-extends when 0.
REQ-009 req_bits_data  in  64  store data, right-aligned.
REQ-010 req_bits_tag  in  4  opaque ID, returned with the response.
REQ-011 resp_valid / resp_ready  out / in  1 / 1  response handshake.
REQ-012 resp_bits_data / resp_bits_tag / resp_bits_isStore / resp_bits_error  out  64 / 4 / 1 / 1  load result (0 for stores), tag, kind, misalignment flag.
REQ-013 mem_dRead_addressInfo_{valid,ready,bits_address,bits_size}  out/in/out/out  1/1/64/2  memory load request.
REQ-014 mem_dRead_data_{valid,ready,bits}  in/out/in  1/1/64  memory load data, right-aligned.
REQ-015 mem_dWrite_storeInfo_{valid,ready,bits_addressInfo_address,bits_addressInfo_size,bits_data}  out/in/out/out/out  1/1/64/2/64  memory store request.

Function
REQ-016 Requests SHALL enter an in-order FIFO; req_ready = !full, with no bypass, so a request offered while full is not accepted even if an entry pops in the same cycle.
REQ-017 A simultaneous push and pop on a non-full, non-empty FIFO SHALL keep the occupancy unchanged; pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-018 FSM states: IDLE, LD_ISSUE, LD_WAIT, ST_ISSUE, RESP; at most one memory transaction is outstanding.
REQ-019 IDLE with a non-empty FIFO SHALL latch the head entry and move next cycle to one of: RESP if the entry is misaligned, else ST_ISSUE for a store, else LD_ISSUE.
REQ-020 Misaligned means address[size-1:0] != 0 for size >= 1; it yields resp_bits_error = 1, resp_bits_data = 0, and no memory access.
REQ-021 LD_ISSUE SHALL hold mem_dRead_addressInfo_valid high with stable address and size until ready, then enter LD_WAIT.
REQ-022 LD_WAIT SHALL drive mem_dRead_data_ready = 1; mem_dRead_data_ready SHALL be 0 in every other state.
REQ-023 In LD_WAIT, on mem_dRead_data_valid the FSM SHALL capture data, keep the low 8/16/32/64 bits per size, extend per signed, and enter RESP.
REQ-024 ST_ISSUE SHALL hold mem_dWrite_storeInfo_valid high with stable fields until ready, then enter RESP; store data SHALL be masked to size.
REQ-025 RESP SHALL hold resp_valid high with stable bits until resp_ready; on that fire the FIFO head pops and the FSM returns to IDLE.
REQ-026 Minimum load latency: req fire at T, mem_dRead addressInfo valid at T+2, data at T+3 or later, resp_valid on the cycle after data.
REQ-027 A mem_dRead_data_valid outside LD_WAIT SHALL be ignored.

Reset
REQ-028 While reset is high, the FIFO SHALL empty and the FSM SHALL enter IDLE.
REQ-029 While reset is high, all valid/ready outputs SHALL be 0, except req_ready which is 1 on the cycle after reset is released.
REQ-030 While reset is high, all bits outputs SHALL be 0.
REQ-031 Reset mid-transaction SHALL discard the in-flight entry with no response; memory data arriving afterwards is ignored per REQ-027.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the size-code constants, the request-entry struct, and the QUEUE_DEPTH default.
REQ-033 A single sub-module req_fifo (parameterised depth and entry type) SHALL implement the queue.

Verification
REQ-034 Load of size 0, signed, at 0x1003; memory returns 0x80 -> resp_bits_data 0xFFFF_FFFF_FFFF_FF80 with the issued tag; same load unsigned -> 0x80.
REQ-035 Store size 1 at 0x2002 with data 0x1234_5678 -> one dWrite carrying address 0x2002, size 1, data 0x5678; then resp with isStore = 1, data 0.
REQ-036 Five back-to-back requests with resp_ready = 0 and QUEUE_DEPTH 4 -> req_ready drops after the 4th accept; the 5th is accepted only on the cycle after the first resp fire.
REQ-037 Load at 0x1001 with size 2 -> resp_bits_error = 1 and no mem_dRead_addressInfo_valid.
REQ-038 Reset asserted in LD_WAIT, then stale data_valid -> no resp_valid; the next load completes normally.
REQ-039 mem_dRead_addressInfo_ready held low for 3 cycles -> valid, address and size stay stable for those 3 cycles.
